// File: rtl/mux4_sel_arbiter_if.sv
// Request/select bundle between the sources, the
// round-robin arbiter and the downstream 4:1 mux.
interface mux4_sel_arbiter_if;
  logic [3:0] req;
  logic       ready;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       valid;
  logic       last;

  modport master (
    input  req,
    input  ready,
    output sel,
    output gnt,
    output valid,
    output last
  );

  modport slave (
    output req,
    output ready,
    input  sel,
    input  gnt,
    input  valid,
    input  last
  );
endinterface

// File: rtl/mux4_sel_arbiter.sv
// Burst-oriented round-robin arbiter driving the
// select of a 4:1 mux with a valid/ready beat channel.
module mux4_sel_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 4
) (
  input  logic           clk,
  input  logic           rst,
  mux4_sel_arbiter_if.master bus
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state;
  logic [1:0]       sel_q;
  logic [3:0]       gnt_q;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] beat_cnt;

  logic       valid;
  logic       last;
  logic       beat;
  logic       rel;
  logic       found;
  logic [1:0] base;
  logic [1:0] win;

  assign valid = (state == GRANT) & bus.req[sel_q];
  assign last  = valid &
                 (beat_cnt == CNT_W'(BURST_LEN - 1));
  assign beat  = valid & bus.ready;
  assign rel   = (state == GRANT) &
                 ((beat & last) | ~bus.req[sel_q]);

  // On release the pointer moves past the current
  // source before the same-cycle re-arbitration.
  assign base = (state == GRANT) ? sel_q + 2'd1 : ptr;

  always_comb begin
    found = 1'b0;
    win   = base;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[base + 2'(i)]) begin
        found = 1'b1;
        win   = base + 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel_q    <= 2'b00;
      gnt_q    <= 4'b0000;
      ptr      <= 2'b00;
      beat_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            state    <= GRANT;
            sel_q    <= win;
            gnt_q    <= 4'b0001 << win;
            beat_cnt <= '0;
          end else begin
            gnt_q <= 4'b0000;
          end
        end
        GRANT: begin
          if (rel) begin
            ptr      <= sel_q + 2'd1;
            beat_cnt <= '0;
            if (found) begin
              sel_q <= win;
              gnt_q <= 4'b0001 << win;
            end else begin
              state <= IDLE;
              gnt_q <= 4'b0000;
            end
          end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel   = sel_q;
  assign bus.gnt   = gnt_q;
  assign bus.valid = valid;
  assign bus.last  = last;

endmodule
